// File: rtl/rx_byte_buffer.sv
// Receive-byte buffer: acks each frame from the ISO7816 rx core and queues {frameErr, data} into a FWFT FIFO.
// Flags at N -> ackFlags at N+1 -> entry on rdValid/rdData at N+2; when full and not popped, the frame is acked and dropped.
module rx_byte_buffer #(
    parameter int DEPTH_LOG2    = 3,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int STORE_ERRORED = 1
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [7:0]               rxData,
    input  logic                     rxDataReady,
    input  logic                     rxFrameError,
    input  logic                     rxOverrun,
    output logic                     ackFlags,
    output logic [7:0]               rdData,
    output logic                     rdFrameError,
    output logic                     rdValid,
    input  logic                     rdReady,
    output logic [DEPTH_LOG2:0]      level,
    output logic                     full,
    output logic                     dropFlag,
    output logic                     overrunFlag,
    output logic [ERR_CNT_WIDTH-1:0] errorCount,
    input  logic                     clearStatus
);
    localparam int                       DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]      LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]      LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0]    PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE    = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_CLEAR
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_flags_q, ack_flags_d;
    logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]      level_q, level_d;
    logic                     drop_flag_q, drop_flag_d;
    logic                     overrun_flag_q, overrun_flag_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [8:0]               mem_q [DEPTH];
    logic [8:0]               head;

    logic capture;
    logic store_en;
    logic fifo_full;
    logic fifo_nempty;
    logic pop;
    logic wr_en;
    logic drop_evt;
    logic err_evt;
    logic ovr_evt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rxDataReady || rxFrameError) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                // hold off until the core has seen the ack and lowered its flags
                if (!rxDataReady && !rxFrameError) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ack_flags_d = (state_d == S_CAPTURE);
    end

    assign capture     = (state_q == S_CAPTURE);
    assign store_en    = capture && ((STORE_ERRORED != 0) || !rxFrameError);
    assign fifo_full   = (level_q == LEVEL_FULL);
    assign fifo_nempty = (level_q != '0);
    assign pop         = fifo_nempty && rdReady;
    // a pop in the same cycle frees the slot the write needs
    assign wr_en       = store_en && (!fifo_full || pop);
    assign drop_evt    = store_en && fifo_full && !pop;
    assign err_evt     = capture && rxFrameError;
    assign ovr_evt     = capture && rxOverrun;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        drop_flag_d    = drop_flag_q;
        overrun_flag_d = overrun_flag_q;
        err_cnt_d      = err_cnt_q;
        if (clearStatus) begin
            drop_flag_d    = 1'b0;
            overrun_flag_d = 1'b0;
            err_cnt_d      = '0;
        end
        // a coincident event overrides the clear
        if (drop_evt) begin
            drop_flag_d = 1'b1;
        end
        if (ovr_evt) begin
            overrun_flag_d = 1'b1;
        end
        if (err_evt) begin
            if (clearStatus) begin
                err_cnt_d = ERR_ONE;
            end else if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            state_q        <= S_IDLE;
            ack_flags_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            drop_flag_q    <= 1'b0;
            overrun_flag_q <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ack_flags_q    <= ack_flags_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            drop_flag_q    <= drop_flag_d;
            overrun_flag_q <= overrun_flag_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    // storage needs no reset: nothing is readable until level says so
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {rxFrameError, rxData};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign rdData       = head[7:0];
    assign rdFrameError = head[8];
    assign rdValid      = fifo_nempty;
    assign ackFlags     = ack_flags_q;
    assign level        = level_q;
    assign full         = fifo_full;
    assign dropFlag     = drop_flag_q;
    assign overrunFlag  = overrun_flag_q;
    assign errorCount   = err_cnt_q;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// Bench for rx_byte_buffer: three instances (default, errored frames not stored, 2-bit error counter) share stimulus.
module tb_rx_byte_buffer;

    logic       clk = 1'b0;
    logic       nReset;
    logic [7:0] rxData;
    logic       rxDataReady, rxFrameError, rxOverrun, rdReady, clearStatus;

    logic       a_ack, a_tag, a_valid, a_full, a_drop, a_ovr;
    logic [7:0] a_data, a_cnt;
    logic [3:0] a_level;
    logic       b_ack, b_tag, b_valid, b_full, b_drop, b_ovr;
    logic [7:0] b_data, b_cnt;
    logic [3:0] b_level;
    logic       c_ack, c_tag, c_valid, c_full, c_drop, c_ovr;
    logic [7:0] c_data;
    logic [1:0] c_cnt;
    logic [3:0] c_level;

    int checks = 0;
    int failures = 0;

    logic [8:0] mq [3][$];
    int         mcnt [3];
    bit         mdrop [3];
    bit         movr [3];

    always #5 clk = ~clk;

    rx_byte_buffer dut_a (
        .clk(clk), .nReset(nReset), .rxData(rxData), .rxDataReady(rxDataReady),
        .rxFrameError(rxFrameError), .rxOverrun(rxOverrun), .ackFlags(a_ack),
        .rdData(a_data), .rdFrameError(a_tag), .rdValid(a_valid), .rdReady(rdReady),
        .level(a_level), .full(a_full), .dropFlag(a_drop), .overrunFlag(a_ovr),
        .errorCount(a_cnt), .clearStatus(clearStatus));

    rx_byte_buffer #(.STORE_ERRORED(0)) dut_b (
        .clk(clk), .nReset(nReset), .rxData(rxData), .rxDataReady(rxDataReady),
        .rxFrameError(rxFrameError), .rxOverrun(rxOverrun), .ackFlags(b_ack),
        .rdData(b_data), .rdFrameError(b_tag), .rdValid(b_valid), .rdReady(rdReady),
        .level(b_level), .full(b_full), .dropFlag(b_drop), .overrunFlag(b_ovr),
        .errorCount(b_cnt), .clearStatus(clearStatus));

    rx_byte_buffer #(.ERR_CNT_WIDTH(2)) dut_c (
        .clk(clk), .nReset(nReset), .rxData(rxData), .rxDataReady(rxDataReady),
        .rxFrameError(rxFrameError), .rxOverrun(rxOverrun), .ackFlags(c_ack),
        .rdData(c_data), .rdFrameError(c_tag), .rdValid(c_valid), .rdReady(rdReady),
        .level(c_level), .full(c_full), .dropFlag(c_drop), .overrunFlag(c_ovr),
        .errorCount(c_cnt), .clearStatus(clearStatus));

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, want);
        end
    endtask

    // reference model: each instance is a bounded queue plus status words
    function automatic int cmax(input int k);
        return (k == 2) ? 3 : 255;
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic fe, input logic ov);
        for (int k = 0; k < 3; k++) begin
            if (fe && mcnt[k] < cmax(k)) mcnt[k]++;
            if (ov) movr[k] = 1'b1;
            if (!fe || k != 1) begin
                if (mq[k].size() < 8) mq[k].push_back({fe, d});
                else mdrop[k] = 1'b1;
            end
        end
    endtask

    task automatic model_pop();
        for (int k = 0; k < 3; k++) begin
            if (mq[k].size() > 0) mq[k].delete(0);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mdrop[k] = 1'b0; movr[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int k = 0; k < 3; k++) mq[k].delete();
    endtask

    task automatic check_dut(input string who, input int k, input logic [3:0] lvl, input logic fl,
                             input logic vld, input logic [7:0] d, input logic t, input logic dr,
                             input logic ov, input int cnt);
        int n;
        n = mq[k].size();
        check($sformatf("%s.level", who), int'(lvl), n);
        check($sformatf("%s.full", who), int'(fl), int'(n == 8));
        check($sformatf("%s.valid", who), int'(vld), int'(n > 0));
        if (n > 0) check($sformatf("%s.head", who), int'({t, d}), int'(mq[k][0]));
        check($sformatf("%s.drop", who), int'(dr), int'(mdrop[k]));
        check($sformatf("%s.ovr", who), int'(ov), int'(movr[k]));
        check($sformatf("%s.errcnt", who), cnt, mcnt[k]);
    endtask

    task automatic check_all(input string tag);
        check_dut({tag, ".a"}, 0, a_level, a_full, a_valid, a_data, a_tag, a_drop, a_ovr, int'(a_cnt));
        check_dut({tag, ".b"}, 1, b_level, b_full, b_valid, b_data, b_tag, b_drop, b_ovr, int'(b_cnt));
        check_dut({tag, ".c"}, 2, c_level, c_full, c_valid, c_data, c_tag, c_drop, c_ovr, int'(c_cnt));
    endtask

    // present one frame, optionally pulsing clearStatus/rdReady during the ack cycle
    task automatic send_frame(input logic [7:0] d, input logic fe, input logic ov, input int hold,
                              input logic cap_clr, input logic cap_pop,
                              output int ack_at, output int acks_a, output int acks_b,
                              output logic v_n1, output logic v_n2, output logic [8:0] popped);
        ack_at = -1; acks_a = 0; acks_b = 0; v_n1 = 1'b0; v_n2 = 1'b0; popped = '0;
        @(posedge clk); #1;
        rxData = d; rxDataReady = 1'b1; rxFrameError = fe; rxOverrun = ov;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_ack) acks_b++;
            if (a_ack) begin
                ack_at = i;
                acks_a++;
                break;
            end
        end
        if (ack_at >= 0) begin
            v_n1 = a_valid;
            popped = {a_tag, a_data};
            clearStatus = cap_clr;
            rdReady = cap_pop;
            @(posedge clk); #1;
            clearStatus = 1'b0;
            rdReady = 1'b0;
            @(negedge clk);
            v_n2 = a_valid;
            if (a_ack) acks_a++;
            if (b_ack) acks_b++;
        end
        repeat (hold) begin
            @(negedge clk);
            if (a_ack) acks_a++;
            if (b_ack) acks_b++;
        end
        @(posedge clk); #1;
        rxDataReady = 1'b0; rxFrameError = 1'b0; rxOverrun = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack) acks_a++;
            if (b_ack) acks_b++;
        end
    endtask

    task automatic frame_std(input logic [7:0] d, input logic fe, input logic ov, input int hold);
        int at, na, nb;
        logic v1, v2;
        logic [8:0] pp;
        send_frame(d, fe, ov, hold, 1'b0, 1'b0, at, na, nb, v1, v2, pp);
        check("ack_latency", at, 1);
        check("ack_pulses_a", na, 1);
        check("ack_pulses_b", nb, 1);
        model_frame(d, fe, ov);
    endtask

    task automatic pop_one(output logic [8:0] got);
        @(posedge clk); #1;
        rdReady = 1'b1;
        @(negedge clk);
        got = {a_tag, a_data};
        @(posedge clk); #1;
        rdReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_checked(input string tag);
        logic [8:0] got, want;
        bit have;
        have = mq[0].size() > 0;
        want = have ? mq[0][0] : 9'h0;
        pop_one(got);
        if (have) check(tag, int'(got), int'(want));
        model_pop();
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1;
        clearStatus = 1'b1;
        @(posedge clk); #1;
        clearStatus = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       ov;
        int         hold;
        logic       exp_tag;
        int         exp_b_lvl;
        int         exp_cnt;
        logic       exp_ovr;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        int at, na, nb;
        logic v1, v2;
        logic [8:0] pp;
        logic [8:0] got;
        int ack_seen;

        tbl[0] = '{8'h3B, 1'b0, 1'b0, 0, 1'b0, 1, 0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 0, 1'b1, 0, 1, 1'b0};
        tbl[2] = '{8'h5A, 1'b0, 1'b0, 5, 1'b0, 1, 1, 1'b0};
        tbl[3] = '{8'hC3, 1'b1, 1'b1, 2, 1'b1, 0, 2, 1'b1};

        nReset = 1'b1; rxData = 8'h00; rxDataReady = 1'b0; rxFrameError = 1'b0;
        rxOverrun = 1'b0; rdReady = 1'b0; clearStatus = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 nReset = 1'b0;
        @(negedge clk);
        check("rst.ack", int'(a_ack), 0);
        check("rst.valid", int'(a_valid), 0);
        check("rst.full", int'(a_full), 0);
        check("rst.level", int'(a_level), 0);
        check_all("rst");

        for (int v = 0; v < 4; v++) begin
            send_frame(tbl[v].d, tbl[v].fe, tbl[v].ov, tbl[v].hold, 1'b0, 1'b0, at, na, nb, v1, v2, pp);
            check($sformatf("vec%0d.ack_latency", v), at, 1);
            check($sformatf("vec%0d.ack_pulses_a", v), na, 1);
            check($sformatf("vec%0d.ack_pulses_b", v), nb, 1);
            check($sformatf("vec%0d.valid_n1", v), int'(v1), 0);
            check($sformatf("vec%0d.valid_n2", v), int'(v2), 1);
            check($sformatf("vec%0d.data", v), int'(a_data), int'(tbl[v].d));
            check($sformatf("vec%0d.tag", v), int'(a_tag), int'(tbl[v].exp_tag));
            check($sformatf("vec%0d.a_level", v), int'(a_level), 1);
            check($sformatf("vec%0d.b_level", v), int'(b_level), tbl[v].exp_b_lvl);
            check($sformatf("vec%0d.a_errcnt", v), int'(a_cnt), tbl[v].exp_cnt);
            check($sformatf("vec%0d.b_errcnt", v), int'(b_cnt), tbl[v].exp_cnt);
            check($sformatf("vec%0d.ovr", v), int'(a_ovr), int'(tbl[v].exp_ovr));
            model_frame(tbl[v].d, tbl[v].fe, tbl[v].ov);
            check_all($sformatf("vec%0d", v));
            pop_one(got);
            model_pop();
            check($sformatf("vec%0d.pop_level", v), int'(a_level), 0);
            check($sformatf("vec%0d.pop_valid", v), int'(a_valid), 0);
        end

        // nine frames into an eight-entry FIFO: the last one is dropped
        clear_pulse();
        for (int i = 0; i < 9; i++) frame_std(8'(i), 1'b0, 1'b0, 0);
        check("full.level", int'(a_level), 8);
        check("full.full", int'(a_full), 1);
        check("full.drop", int'(a_drop), 1);
        check_all("full");
        for (int i = 0; i < 8; i++) begin
            pop_one(got);
            model_pop();
            check($sformatf("full.pop%0d", i), int'(got), i);
        end
        check("full.drained", int'(a_valid), 0);

        // overrun, then a frame error coinciding with clearStatus
        frame_std(8'h77, 1'b0, 1'b1, 0);
        check("ovr.flag", int'(a_ovr), 1);
        send_frame(8'h66, 1'b1, 1'b0, 0, 1'b1, 1'b0, at, na, nb, v1, v2, pp);
        model_clear();
        model_frame(8'h66, 1'b1, 1'b0);
        check("clr.errcnt", int'(a_cnt), 1);
        check("clr.drop", int'(a_drop), 0);
        check("clr.ovr", int'(a_ovr), 0);
        check_all("clr");
        for (int i = 0; i < 8 && mq[0].size() > 0; i++) pop_checked("clr.pop");

        // pop coinciding with the write at full
        clear_pulse();
        for (int i = 0; i < 8; i++) frame_std(8'h10 + 8'(i), 1'b0, 1'b0, 0);
        send_frame(8'h18, 1'b0, 1'b0, 0, 1'b0, 1'b1, at, na, nb, v1, v2, pp);
        model_pop();
        model_frame(8'h18, 1'b0, 1'b0);
        check("fullpop.popped", int'(pp), 9'h010);
        check("fullpop.level", int'(a_level), 8);
        check("fullpop.drop", int'(a_drop), 0);
        check_all("fullpop");
        for (int i = 0; i < 8; i++) begin
            pop_one(got);
            model_pop();
            check($sformatf("fullpop.pop%0d", i), int'(got), 16'h11 + i);
        end

        // error counter saturation on the 2-bit instance
        clear_pulse();
        for (int i = 0; i < 5; i++) frame_std(8'hE0 + 8'(i), 1'b1, 1'b0, 0);
        check("sat.c_errcnt", int'(c_cnt), 3);
        check("sat.a_errcnt", int'(a_cnt), 5);
        check_all("sat");
        for (int i = 0; i < 8 && mq[0].size() > 0; i++) pop_checked("sat.pop");

        // reset asserted during the capture cycle
        frame_std(8'h42, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        rxData = 8'h43; rxDataReady = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ack) begin
                ack_seen = 1;
                break;
            end
        end
        check("rstcap.ack_seen", ack_seen, 1);
        nReset = 1'b1;
        @(posedge clk); #1;
        nReset = 1'b0; rxDataReady = 1'b0;
        model_reset();
        @(negedge clk);
        check("rstcap.ack", int'(a_ack), 0);
        check("rstcap.valid", int'(a_valid), 0);
        check("rstcap.errcnt", int'(a_cnt), 0);
        check_all("rstcap");
        repeat (3) begin
            @(negedge clk);
            check("rstcap.idle_ack", int'(a_ack), 0);
        end

        // randomized traffic against the queue model
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                frame_std(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          int'($urandom_range(0, 3)));
            end else if (r < 90) begin
                pop_checked("rnd.pop");
            end else begin
                clear_pulse();
            end
            check_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_byte_buffer.md
Name: rx_byte_buffer

Overview:
- Consumes the byte-level outputs of the ISO7816 receive core: received byte, ready flag, frame-error flag and overrun flag.
- Acknowledges each received frame back to the core with a one-cycle `ackFlags` pulse.
- Queues each byte, tagged with its frame-error status, into a first-word-fall-through FIFO with a valid/ready read port.
- Keeps sticky overrun and drop status plus a saturating frame-error counter for the host/protocol layer.

Parameters:
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 entries; each entry is 9 bits, {frameErr, data[7:0]}.
- ERR_CNT_WIDTH, 8: width of the saturating frame-error counter.
- STORE_ERRORED, 1: 1 = frames with a frame error are queued with the tag set; 0 = they are acked and counted, but not queued.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nReset  in  1  synchronous, active-high reset; 1 = reset, sampled on the clk edge.
- rxData  in  8  byte from the receive core (its dataOut).
- rxDataReady  in  1  receive core dataOutReadyFlag.
- rxFrameError  in  1  receive core frameErrorFlag.
- rxOverrun  in  1  receive core overrunErrorFlag.
- ackFlags  out  1  one-cycle acknowledge to the receive core.
- rdData  out  8  head-of-FIFO data; valid only while rdValid=1.
- rdFrameError  out  1  head-of-FIFO error tag.
- rdValid  out  1  FIFO not empty.
- rdReady  in  1  consumer pops the head when rdValid & rdReady.
- level  out  DEPTH_LOG2+1  number of stored entries.
- full  out  1  level == 2**DEPTH_LOG2.
- dropFlag  out  1  sticky: a frame arrived while the FIFO was full.
- overrunFlag  out  1  sticky: rxOverrun was seen at capture.
- errorCount  out  ERR_CNT_WIDTH  saturating count of frame errors.
- clearStatus  in  1  clears dropFlag, overrunFlag and errorCount.

Behaviour:
- Reset (nReset=1 at an edge):
  - state=IDLE; FIFO pointers and level=0.
  - ackFlags=0, rdValid=0, full=0, dropFlag=0, overrunFlag=0, errorCount=0.
  - rdData and rdFrameError are don't-care while rdValid=0.
  - Reset mid-capture discards the in-flight frame; FIFO contents are lost.
- FSM, 3 states:
  - IDLE: if (rxDataReady | rxFrameError) at an edge -> CAPTURE.
  - CAPTURE: lasts one cycle. ackFlags=1. The entry is written at the end of this cycle from the current rxData, rxFrameError and rxOverrun. -> WAIT_CLEAR.
  - WAIT_CLEAR: ackFlags=0. Stay until rxDataReady=0 and rxFrameError=0, then -> IDLE. This prevents double capture of one frame.
- Latency:
  - Flags first high in cycle N -> ackFlags=1 in cycle N+1.
  - The entry is visible on rdValid/rdData in cycle N+2 (FWFT).
  - rdData is driven directly from FIFO storage at the read pointer; there is no extra register stage.
- Write rules in CAPTURE:
  - The error tag equals rxFrameError. Frame error takes precedence when both flags are high.
  - If rxFrameError=1, errorCount increments; it saturates at all-ones and never wraps.
  - If rxFrameError=1 and STORE_ERRORED=0, nothing is written.
  - If rxOverrun=1, overrunFlag is set.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped, dropFlag is set, and ackFlags is still issued.
  - If the FIFO is full and a pop occurs in the same cycle, the write is accepted; level stays 2**DEPTH_LOG2.
- Read rules:
  - A pop happens when rdValid & rdReady.
  - Pop with no write: level decrements.
  - Write and pop in the same cycle with level>0: level unchanged.
  - Write into an empty FIFO: rdValid rises the next cycle; a same-cycle pop has no effect because rdValid=0.
  - Pointers are DEPTH_LOG2 bits and wrap naturally modulo depth. level is tracked as a separate counter.
- clearStatus:
  - Clears dropFlag, overrunFlag and errorCount at the edge.
  - If a set or increment event coincides with clearStatus, the event wins: flag=1, and the counter becomes 1 rather than 0.
  - clearStatus does not affect FIFO contents or FSM state.

Test Plan:
- Good frame: rxData=0x3B and rxDataReady=1 held until ack -> ackFlags exactly one cycle (N+1); rdValid=1 with rdData=0x3B, rdFrameError=0 at N+2; level=1; pop -> level=0, rdValid=0.
- Parity error: rxFrameError=1 with rxData=0xA5, STORE_ERRORED=1 -> entry 0xA5 with rdFrameError=1, errorCount=1. Repeat with STORE_ERRORED=0 -> errorCount=1, level=0, ackFlags still pulsed.
- Full FIFO (DEPTH_LOG2=3): send 9 frames 0x00..0x08 with rdReady=0 -> level=8, full=1, dropFlag=1, 9th byte absent. Then pop 8 -> data read out 0x00..0x07 in order.
- Simultaneous write and pop at full: level=8, rdReady=1 in the CAPTURE cycle -> write accepted, level stays 8, dropFlag stays 0, order preserved.
- Flags held high for 5 cycles after ack -> only one entry is written and ackFlags pulses once. Overrun: rxOverrun=1 at capture -> overrunFlag=1. clearStatus in the same cycle as a frame error -> errorCount=1, flags otherwise cleared.
- Saturation and reset: ERR_CNT_WIDTH=2, 5 error frames -> errorCount=3. Assert nReset during CAPTURE -> next cycle all outputs at reset values and FSM in IDLE.
